sr_config_sequencer: RTL and testbench
======================================

Name: sr_config_sequencer

Overview:
- Controller that writes one WIDTH-bit configuration word serially into the TMIIa on-chip shift register and captures the word shifted back out of the chain.
- Sits between the host-facing register/FIFO interface and the shift-register clock generator.
- Drives the generator's start and count inputs, supplies serial data, issues the load strobe, and returns readback data with a valid pulse.

Parameters:
- WIDTH, 170: number of bits in the shift-register chain.
- CNT_WIDTH, 8: bit counter width; 2**CNT_WIDTH > WIDTH is required.
- LOAD_CYCLES, 2: number of cycles load_sr stays high after shifting, range 1..15.

Ports:
- clk  in  1  control clock; same clock that feeds the shift-register clock generator.
- rst  in  1  asynchronous, active-high reset.
- din  in  WIDTH  configuration word; bit WIDTH-1 is shifted first.
- din_valid  in  1  din holds a word to write.
- din_ready  out  1  block can accept a word.
- abort  in  1  synchronous request to abandon the current operation.
- start  out  1  one-cycle pulse to the clock generator.
- count  out  CNT_WIDTH  bit counter to the clock generator.
- sr_din  out  1  serial data into the chain.
- sr_dout  in  1  serial data out of the chain.
- load_sr  out  1  latch strobe for the chain's parallel register.
- dout  out  WIDTH  captured readback word.
- dout_valid  out  1  one-cycle pulse; dout is valid in that cycle.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst=1) values:
  - State is IDLE.
  - din_ready=1; start=0; count=0; sr_din=0; load_sr=0; dout=0; dout_valid=0; busy=0.
  - Internal tx/rx registers cleared.
- All outputs are registered.
- States and transitions: IDLE -> START -> SHIFT -> LOAD -> DONE -> IDLE.
- IDLE:
  - din_ready=1.
  - On din_valid&&din_ready: latch din into tx, clear rx and count, go to START.
  - din_ready drops the cycle after acceptance.
- START:
  - start=1 for exactly this one cycle.
  - sr_din = tx[WIDTH-1].
  - count stays 0.
  - Next state is SHIFT.
- SHIFT, one bit per cycle while count<WIDTH:
  - rx <= {rx[WIDTH-2:0], sr_dout}.
  - tx <= tx<<1.
  - sr_din <= next tx MSB.
  - count <= count+1.
  - When count reaches WIDTH (after exactly WIDTH SHIFT cycles), go to LOAD; count holds at WIDTH.
  - sr_din is 0 once count reaches WIDTH.
- LOAD:
  - load_sr=1 for LOAD_CYCLES consecutive cycles, timed by an internal 4-bit counter.
  - count holds at WIDTH.
  - Then go to DONE.
- DONE:
  - dout <= rx and dout_valid=1 for one cycle.
  - count returns to 0.
  - Next state is IDLE.
- Latency: from the accept cycle to the dout_valid cycle is 1 + WIDTH + LOAD_CYCLES + 1 cycles. With the defaults this is 174.
- abort, sampled only in START or SHIFT:
  - Next cycle: state is IDLE, count=0, sr_din=0.
  - No load_sr and no dout_valid are issued.
  - dout is unchanged.
- abort in LOAD or DONE is ignored, so the load always completes once started.
- abort in IDLE has no effect.
- din_valid while busy is ignored; no word is lost, because din_ready=0 during that time.
- Reset mid-operation: immediate return to reset values, including load_sr=0. A partial chain write is not retried.
- Back-to-back operation: a word can be accepted in the cycle after DONE, since the block is in IDLE with din_ready=1.
- count never exceeds WIDTH and never wraps.

Decomposition:
- Shared package sr_pkg holds:
  - state encoding as one-hot localparams: IDLE, START, SHIFT, LOAD, DONE;
  - default WIDTH/CNT_WIDTH constants, shared with the clock generator so both use identical values.
- One natural sub-module, sr_bit_engine, holds the tx/rx shift registers, the serial-data register and the bit counter. It is controlled by shift_en, clear and load_word.
- The FSM and the load timer stay in the top level.

Test Plan:
- Single write with WIDTH=170, din = 170'h2AAA…A (alternating bits), sr_dout looped to sr_din through a 170-deep model chain:
  - start pulses once, 1 cycle after accept;
  - sr_din emits din MSB-first over 170 cycles;
  - load_sr is high for 2 cycles;
  - dout_valid pulses 174 cycles after accept;
  - dout equals the previous chain contents (0 after reset).
- Two consecutive writes A then B: the second dout equals A; busy stays high throughout each operation; din_ready=0 until the cycle after DONE.
- Abort asserted at SHIFT with count=50: next cycle state=IDLE, count=0, din_ready=1; load_sr and dout_valid never assert.
- Async rst pulse during LOAD: load_sr falls immediately, with no clock edge required; all outputs return to reset values.
- din_valid held high while busy: exactly one word accepted per operation; the second word is accepted only after DONE.
- WIDTH=5, LOAD_CYCLES=1: count sequence is 0,0,1,2,3,4,5,5,0; latency from accept to dout_valid is 8 cycles.

Source files
------------

// File: rtl/sr_pkg.sv
// Shared constants and state encoding for the shift-register configuration path.
// Widths here are also consumed by the shift-register clock generator.
package sr_pkg;

    localparam int DEF_WIDTH       = 170;
    localparam int DEF_CNT_WIDTH   = 8;
    localparam int DEF_LOAD_CYCLES = 2;

    localparam logic [4:0] S_IDLE  = 5'b00001;
    localparam logic [4:0] S_START = 5'b00010;
    localparam logic [4:0] S_SHIFT = 5'b00100;
    localparam logic [4:0] S_LOAD  = 5'b01000;
    localparam logic [4:0] S_DONE  = 5'b10000;

    typedef enum logic [4:0] {
        IDLE  = S_IDLE,
        START = S_START,
        SHIFT = S_SHIFT,
        LOAD  = S_LOAD,
        DONE  = S_DONE
    } state_t;

endpackage

// File: rtl/sr_bit_engine.sv
// Serial datapath: tx/rx shift registers, serial-out register and bit counter.
// Ports: clk, rst, load_word/clear/shift_en controls, din word, sr_dout in,
//        count, sr_din, rx (captured readback) out.
module sr_bit_engine
    import sr_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_word,
    input  logic                 clear,
    input  logic                 shift_en,
    input  logic [WIDTH-1:0]     din,
    input  logic                 sr_dout,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 sr_din,
    output logic [WIDTH-1:0]     rx
);

    // tx holds only the bits not yet presented; the current bit sits in sr_din.
    // Zeros fill from the bottom, so sr_din drops to 0 after the last bit.
    logic [WIDTH-2:0] tx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx     <= '0;
            rx     <= '0;
            count  <= '0;
            sr_din <= 1'b0;
        end else if (load_word) begin
            tx     <= din[WIDTH-2:0];
            rx     <= '0;
            count  <= '0;
            sr_din <= din[WIDTH-1];
        end else if (clear) begin
            count  <= '0;
            sr_din <= 1'b0;
        end else if (shift_en) begin
            tx     <= tx << 1;
            rx     <= {rx[WIDTH-2:0], sr_dout};
            count  <= count + CNT_WIDTH'(1);
            sr_din <= tx[WIDTH-2];
        end
    end

endmodule

// File: rtl/sr_config_sequencer.sv
// Writes one WIDTH-bit word into the on-chip chain and returns the word shifted out.
// Ports: clk, rst, din/din_valid/din_ready, abort, start/count to clock generator,
//        sr_din/sr_dout serial, load_sr strobe, dout/dout_valid readback, busy.
module sr_config_sequencer
    import sr_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int LOAD_CYCLES = DEF_LOAD_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic                 abort,
    output logic                 start,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 sr_din,
    input  logic                 sr_dout,
    output logic                 load_sr,
    output logic [WIDTH-1:0]     dout,
    output logic                 dout_valid,
    output logic                 busy
);

    state_t           state, state_n;
    logic [3:0]       ltimer;
    logic             load_word, clear, shift_en;
    logic             cnt_full, load_last;
    logic [WIDTH-1:0] rx;

    sr_bit_engine #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_engine (
        .clk       (clk),
        .rst       (rst),
        .load_word (load_word),
        .clear     (clear),
        .shift_en  (shift_en),
        .din       (din),
        .sr_dout   (sr_dout),
        .count     (count),
        .sr_din    (sr_din),
        .rx        (rx)
    );

    always_comb begin
        state_n   = state;
        load_word = 1'b0;
        clear     = 1'b0;
        shift_en  = 1'b0;
        cnt_full  = (count == CNT_WIDTH'(WIDTH));
        load_last = (ltimer == 4'(LOAD_CYCLES - 1));
        unique case (state)
            IDLE: begin
                if (din_valid && din_ready) begin
                    load_word = 1'b1;
                    state_n   = START;
                end
            end
            // The first bit is clocked out on the edge leaving START.
            START: begin
                if (abort) begin
                    clear   = 1'b1;
                    state_n = IDLE;
                end else begin
                    shift_en = 1'b1;
                    state_n  = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    clear   = 1'b1;
                    state_n = IDLE;
                end else if (cnt_full) begin
                    state_n = LOAD;
                end else begin
                    shift_en = 1'b1;
                end
            end
            // abort deliberately ignored: a started load always completes.
            LOAD: begin
                if (load_last) begin
                    clear   = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ltimer     <= 4'd0;
            din_ready  <= 1'b1;
            start      <= 1'b0;
            load_sr    <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            ltimer     <= (state == LOAD) ? ltimer + 4'd1 : 4'd0;
            din_ready  <= (state_n == IDLE);
            start      <= (state_n == START);
            load_sr    <= (state_n == LOAD);
            dout_valid <= (state_n == DONE);
            busy       <= (state_n != IDLE);
            if (state_n == DONE) begin
                dout <= rx;
            end
        end
    end

endmodule

// File: tb/tb_sr_config_sequencer.sv
// Testbench for sr_config_sequencer: default build plus a WIDTH=5 build.
// Ports: none (top-level bench).
module tb_sr_config_sequencer;

    localparam int W   = 170;
    localparam int CW  = 8;
    localparam int L   = 2;
    localparam int LAT = W + L + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  din = '0;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic          abort = 1'b0;
    logic          start;
    logic [CW-1:0] count;
    logic          sr_din;
    logic          sr_dout;
    logic          load_sr;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic          busy;
    logic [W-1:0]  chain = '0;

    logic [4:0] d5_din = '0;
    logic       d5_valid = 1'b0;
    logic       d5_ready;
    logic       d5_abort = 1'b0;
    logic       d5_start;
    logic [3:0] d5_count;
    logic       d5_sr_din;
    logic       d5_sr_dout;
    logic       d5_load;
    logic [4:0] d5_dout;
    logic       d5_dv;
    logic       d5_busy;
    logic [4:0] ch5 = '0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] sb[$];

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] exp;
    } vec_t;
    vec_t vecs[4];

    always #5 clk = ~clk;

    sr_config_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .abort      (abort),
        .start      (start),
        .count      (count),
        .sr_din     (sr_din),
        .sr_dout    (sr_dout),
        .load_sr    (load_sr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    sr_config_sequencer #(
        .WIDTH       (5),
        .CNT_WIDTH   (4),
        .LOAD_CYCLES (1)
    ) dut5 (
        .clk        (clk),
        .rst        (rst),
        .din        (d5_din),
        .din_valid  (d5_valid),
        .din_ready  (d5_ready),
        .abort      (d5_abort),
        .start      (d5_start),
        .count      (d5_count),
        .sr_din     (d5_sr_din),
        .sr_dout    (d5_sr_dout),
        .load_sr    (d5_load),
        .dout       (d5_dout),
        .dout_valid (d5_dv),
        .busy       (d5_busy)
    );

    // External chain models: clocked once per bit the generator is asked for.
    assign sr_dout    = chain[W-1];
    assign d5_sr_dout = ch5[4];

    always @(posedge clk) begin
        if (busy && !abort && !load_sr && !dout_valid &&
            count < CW'(W) && (start || count != '0))
            chain <= {chain[W-2:0], sr_din};
    end

    always @(posedge clk) begin
        if (d5_busy && !d5_load && !d5_dv &&
            d5_count < 4'd5 && (d5_start || d5_count != 4'd0))
            ch5 <= {ch5[3:0], d5_sr_din};
    end

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && dout_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: dout_valid with no word pending");
            end else begin
                chk("sb_dout", dout, sb.pop_front());
            end
        end
    end

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 20 && !din_ready; i++) @(negedge clk);
        if (!din_ready) chk({tag, "_ready_timeout"}, W'(din_ready), W'(1));
    endtask

    task automatic do_write(input logic [W-1:0] w, input logic [W-1:0] expv,
                            input string tag);
        int starts, start_t, loads, lat, bad_sr, bad_busy;
        logic exp_bit;
        logic [W-1:0] got;
        starts = 0; start_t = -1; loads = 0; lat = -1;
        bad_sr = 0; bad_busy = 0; got = '0;
        @(negedge clk);
        din = w;
        din_valid = 1'b1;
        wait_ready(tag);
        sb.push_back(chain);
        @(negedge clk);
        din_valid = 1'b0;
        for (int t = 1; t <= LAT + 20; t++) begin
            exp_bit = (t <= W) ? w[(t <= W) ? W - t : 0] : 1'b0;
            if (sr_din !== exp_bit) bad_sr++;
            if (start) begin
                starts++;
                start_t = t;
            end
            if (load_sr) loads++;
            if (!busy || din_ready) bad_busy++;
            if (dout_valid) begin
                lat = t;
                got = dout;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_start_pulses"}, W'(starts), W'(1));
        chk({tag, "_start_cycle"}, W'(start_t), W'(1));
        chk({tag, "_sr_din_errs"}, W'(bad_sr), W'(0));
        chk({tag, "_load_cycles"}, W'(loads), W'(L));
        chk({tag, "_latency"}, W'(lat), W'(LAT));
        chk({tag, "_busy_errs"}, W'(bad_busy), W'(0));
        chk({tag, "_dout"}, got, expv);
        @(negedge clk);
        chk({tag, "_idle_after"}, W'({din_ready, busy}), W'(2'b10));
    endtask

    initial begin
        int bad, acc;
        int acc_t[2];
        int exp5[9];
        logic [3:0] cnt5[9];
        logic [8:0] vmask;
        logic [4:0] d5_first;

        vecs[0].din = {85{2'b10}};
        vecs[0].exp = '0;
        vecs[1].din = '1;
        vecs[1].exp = vecs[0].din;
        vecs[2].din = {85{2'b01}};
        vecs[2].exp = vecs[1].din;
        vecs[3].din = {5{34'h2_DEAD_BEEF}};
        vecs[3].exp = vecs[2].din;
        exp5 = '{0, 0, 1, 2, 3, 4, 5, 5, 0};

        repeat (3) @(negedge clk);
        chk("rst_outputs",
            W'({din_ready, start, count, sr_din, load_sr, dout_valid, busy}),
            W'({1'b1, 13'b0}));
        chk("rst_dout", dout, '0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++)
            do_write(vecs[i].din, vecs[i].exp, $sformatf("vec%0d", i));

        // abort in SHIFT at count 50
        @(negedge clk);
        din = {10{17'h1_2345}};
        din_valid = 1'b1;
        wait_ready("abort");
        @(negedge clk);
        din_valid = 1'b0;
        for (int i = 0; i < 300 && count != CW'(50); i++) @(negedge clk);
        chk("abort_reach50", W'(count), W'(50));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", W'({busy, din_ready, count, sr_din}),
            W'({1'b0, 1'b1, 8'd0, 1'b0}));
        bad = 0;
        for (int i = 0; i < LAT + 20; i++) begin
            if (load_sr || dout_valid) bad++;
            @(negedge clk);
        end
        chk("abort_no_load", W'(bad), W'(0));
        chk("abort_dout_kept", dout, vecs[3].exp);

        // async reset while load_sr is high
        din = vecs[0].din;
        din_valid = 1'b1;
        wait_ready("rstload");
        sb.push_back(chain);
        @(negedge clk);
        din_valid = 1'b0;
        for (int i = 0; i < LAT + 20 && !load_sr; i++) @(negedge clk);
        chk("rst_reach_load", W'(load_sr), W'(1));
        #2 rst = 1'b1;
        #1;
        chk("rst_async_outputs",
            W'({din_ready, start, count, sr_din, load_sr, dout_valid, busy}),
            W'({1'b1, 13'b0}));
        chk("rst_async_dout", dout, '0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // din_valid held through a whole operation
        din = vecs[2].din;
        din_valid = 1'b1;
        acc = 0;
        acc_t[0] = 0;
        acc_t[1] = 0;
        for (int c = 0; c < 3 * LAT && acc < 2; c++) begin
            if (din_ready) begin
                sb.push_back(chain);
                acc_t[acc] = c;
                acc++;
            end
            @(negedge clk);
            if (acc == 1) din = vecs[3].din;
        end
        din_valid = 1'b0;
        chk("held_accepts", W'(acc), W'(2));
        chk("held_gap", W'(acc_t[1] - acc_t[0]), W'(LAT + 1));
        for (int i = 0; i < LAT + 20 && busy; i++) @(negedge clk);
        chk("held_done", W'(busy), W'(0));
        repeat (2) @(negedge clk);
        chk("sb_empty", W'(sb.size()), W'(0));

        // WIDTH=5, LOAD_CYCLES=1 build
        chk("w5_ready", W'(d5_ready), W'(1));
        d5_din = 5'b10110;
        d5_valid = 1'b1;
        d5_first = '1;
        vmask = '0;
        for (int i = 0; i < 9; i++) begin
            cnt5[i] = d5_count;
            vmask[i] = d5_dv;
            if (i == 8) d5_first = d5_dout;
            @(negedge clk);
            if (i == 0) d5_valid = 1'b0;
        end
        for (int i = 0; i < 9; i++)
            chk($sformatf("w5_count%0d", i), W'(cnt5[i]), W'(exp5[i]));
        chk("w5_valid_at8", W'(vmask), W'(9'h100));
        chk("w5_dout_first", W'(d5_first), W'(0));
        chk("w5_b2b_ready", W'(d5_ready), W'(1));
        d5_din = 5'b01101;
        d5_valid = 1'b1;
        @(negedge clk);
        d5_valid = 1'b0;
        for (int i = 0; i < 20 && !d5_dv; i++) @(negedge clk);
        chk("w5_dout_second", W'(d5_dout), W'(5'b10110));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
